// File: rtl/kamus_pkg.sv
// Shared types for the kamus self-test sequencer.
package kamus_pkg;

  typedef enum logic [1:0] {
    CHK_NONE   = 2'd0,
    CHK_DMEM   = 2'd1,
    CHK_PC_REL = 2'd2
  } chk_mode_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    chk_mode_e   chk;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } selftest_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } selftest_state_e;

endpackage

// File: rtl/kamus_selftest_prog_ram.sv
// Program store: DEPTH entries, one synchronous write port and one read port.
// The read is combinational from flops with write forwarding, so the caller
// can look up the next entry one cycle ahead and register it.
module kamus_selftest_prog_ram
  import kamus_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  selftest_entry_t          wr_entry_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output selftest_entry_t          rd_entry_o
);

  selftest_entry_t mem_q [DEPTH];

  // Entry storage; intentionally not reset so programs survive a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_entry_i;
  end

  // A write in the same cycle as the lookup wins, so write+start sees new data.
  assign rd_entry_o = (we_i && (wr_idx_i == rd_idx_i)) ? wr_entry_i : mem_q[rd_idx_i];

endmodule

// File: rtl/kamus_selftest_seq.sv
// Instruction sequencer and result checker for kamus_core self-test.
module kamus_selftest_seq
  import kamus_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int HOLD_CYCLES  = 5,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       prog_we_i,
  input  logic [$clog2(DEPTH)-1:0]   prog_idx_i,
  input  logic [31:0]                prog_instr_i,
  input  logic [1:0]                 prog_chk_i,
  input  logic [31:0]                prog_exp_addr_i,
  input  logic [31:0]                prog_exp_data_i,
  input  logic [$clog2(DEPTH+1)-1:0] len_i,
  input  logic                       start_i,
  output logic [31:0]                instr_o,
  input  logic [31:0]                l1i_instr_addr_i,
  input  logic [31:0]                l1d_addr_i,
  input  logic [31:0]                l1d_wr_data_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic [$clog2(DEPTH+1)-1:0] err_cnt_o,
  output logic [$clog2(DEPTH)-1:0]   fail_idx_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(DEPTH);
  localparam logic [LW-1:0] ERR_MAX   = '1;

  selftest_state_e state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [LW-1:0]   len_q, len_d;
  logic [31:0]     pc_snap_q, pc_snap_d;
  selftest_entry_t cur_q, cur_d;
  logic [31:0]     instr_q, instr_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [LW-1:0]   err_q, err_d;
  logic [IW-1:0]   fidx_q, fidx_d;

  selftest_entry_t rd_entry, wr_entry;
  logic            idle_like, start_go, ram_we, mismatch, last_entry;
  logic [LW-1:0]   len_eff;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_go   = start_i && idle_like;
  assign ram_we     = prog_we_i && idle_like;
  assign len_eff    = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign last_entry = (LW'(idx_q) == (len_q - LW'(1)));
  assign wr_entry   = '{instr: prog_instr_i, chk: chk_mode_e'(prog_chk_i),
                        exp_addr: prog_exp_addr_i, exp_data: prog_exp_data_i};

  kamus_selftest_prog_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i      (clk_i),
    .we_i       (ram_we),
    .wr_idx_i   (prog_idx_i),
    .wr_entry_i (wr_entry),
    .rd_idx_i   (idx_d),
    .rd_entry_o (rd_entry)
  );

  // Check-cycle comparison of the core buses against the current entry.
  always_comb begin
    mismatch = 1'b0;
    if (state_q == ST_CHECK) begin
      case (cur_q.chk)
        CHK_DMEM:   mismatch = (l1d_addr_i != cur_q.exp_addr) || (l1d_wr_data_i != cur_q.exp_data);
        CHK_PC_REL: mismatch = (l1i_instr_addr_i != (pc_snap_q + cur_q.exp_addr));
        default:    mismatch = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_i) state_d = (len_eff == '0) ? ST_DONE : ST_RUN;
      ST_RUN:           if (hold_q == HOLD_LAST) state_d = ST_CHECK;
      ST_CHECK:         state_d = (last_entry || (mismatch && (STOP_ON_FAIL != 0))) ? ST_DONE : ST_RUN;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Counters, PC snapshot and result bookkeeping.
  always_comb begin
    idx_d     = idx_q;
    hold_d    = hold_q;
    len_d     = len_q;
    pc_snap_d = pc_snap_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    if (start_go) begin
      idx_d  = '0;
      hold_d = '0;
      len_d  = len_eff;
      err_d  = '0;
      fidx_d = '0;
    end
    if (state_q == ST_RUN) begin
      if (hold_q == '0) pc_snap_d = l1i_instr_addr_i;
      if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
    end
    if (state_q == ST_CHECK) begin
      if (mismatch) begin
        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        if (err_q == '0) fidx_d = idx_q;
      end
      if (state_d == ST_RUN) begin
        idx_d  = idx_q + 1'b1;
        hold_d = '0;
      end
    end
  end

  // Registered outputs; the entry register reloads whenever a new entry begins.
  always_comb begin
    cur_d   = ((state_d == ST_RUN) && (state_q != ST_RUN)) ? rd_entry : cur_q;
    busy_d  = (state_d == ST_RUN) || (state_d == ST_CHECK);
    instr_d = busy_d ? cur_d.instr : NOP_INSTR;
    done_d  = (state_d == ST_DONE);
    pass_d  = done_d && (err_d == '0);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      hold_q    <= '0;
      len_q     <= '0;
      pc_snap_q <= '0;
      cur_q     <= '0;
      instr_q   <= NOP_INSTR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fidx_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      pc_snap_q <= pc_snap_d;
      cur_q     <= cur_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
    end
  end

  assign instr_o    = instr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign fail_idx_o = fidx_q;

endmodule

// File: tb/tb_kamus_selftest_seq.sv
// Bench for kamus_selftest_seq: two instances (run-all and stop-on-fail)
// share stimulus; a per-entry model of the core's bus activity predicts results.
module tb_kamus_selftest_seq;

  localparam int DEPTH = 16;
  localparam int H     = 5;
  localparam int H1    = H + 1;
  localparam int IW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int MAXC  = DEPTH * H1 + 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, prog_we_i, start_i;
  logic [IW-1:0] prog_idx_i;
  logic [31:0]   prog_instr_i, prog_exp_addr_i, prog_exp_data_i;
  logic [1:0]    prog_chk_i;
  logic [LW-1:0] len_i;
  logic [31:0]   l1i_addr, l1d_addr, l1d_data;

  logic [31:0]   instr_w [2];
  logic          busy_w [2], done_w [2], pass_w [2];
  logic [LW-1:0] err_w [2];
  logic [IW-1:0] fidx_w [2];

  kamus_selftest_seq #(.DEPTH(DEPTH), .HOLD_CYCLES(H), .STOP_ON_FAIL(0)) u_run (
    .clk_i(clk), .rst_i(rst_i), .prog_we_i(prog_we_i), .prog_idx_i(prog_idx_i),
    .prog_instr_i(prog_instr_i), .prog_chk_i(prog_chk_i), .prog_exp_addr_i(prog_exp_addr_i),
    .prog_exp_data_i(prog_exp_data_i), .len_i(len_i), .start_i(start_i), .instr_o(instr_w[0]),
    .l1i_instr_addr_i(l1i_addr), .l1d_addr_i(l1d_addr), .l1d_wr_data_i(l1d_data),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]), .err_cnt_o(err_w[0]),
    .fail_idx_o(fidx_w[0]));

  kamus_selftest_seq #(.DEPTH(DEPTH), .HOLD_CYCLES(H), .STOP_ON_FAIL(1)) u_stop (
    .clk_i(clk), .rst_i(rst_i), .prog_we_i(prog_we_i), .prog_idx_i(prog_idx_i),
    .prog_instr_i(prog_instr_i), .prog_chk_i(prog_chk_i), .prog_exp_addr_i(prog_exp_addr_i),
    .prog_exp_data_i(prog_exp_data_i), .len_i(len_i), .start_i(start_i), .instr_o(instr_w[1]),
    .l1i_instr_addr_i(l1i_addr), .l1d_addr_i(l1d_addr), .l1d_wr_data_i(l1d_data),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]), .err_cnt_o(err_w[1]),
    .fail_idx_o(fidx_w[1]));

  int checks = 0;
  int errors = 0;

  // Program image plus what the emulated core does while each entry runs:
  // c_a/c_d are its L1D outputs at the check cycle, c_po its PC advance.
  logic [31:0] m_instr [DEPTH], m_ea [DEPTH], m_ed [DEPTH];
  logic [31:0] c_a [DEPTH], c_d [DEPTH], c_po [DEPTH];
  int          m_chk [DEPTH];

  task automatic load(input int k, input logic [31:0] ins, input int chk,
                      input logic [31:0] ea, input logic [31:0] ed,
                      input logic [31:0] ca, input logic [31:0] cd, input logic [31:0] cpo);
    prog_we_i = 1'b1; prog_idx_i = IW'(k); prog_instr_i = ins; prog_chk_i = 2'(chk);
    prog_exp_addr_i = ea; prog_exp_data_i = ed;
    @(posedge clk); #1;
    prog_we_i = 1'b0;
    m_instr[k] = ins; m_chk[k] = chk; m_ea[k] = ea; m_ed[k] = ed;
    c_a[k] = ca; c_d[k] = cd; c_po[k] = cpo;
  endtask

  task automatic rand_entry(input int k);
    logic [31:0] ea, ed;
    bit pa, pd;
    ea = $urandom; ed = $urandom;
    pa = 1'($urandom_range(0, 3) != 0); pd = 1'($urandom_range(0, 3) != 0);
    load(k, $urandom, $urandom_range(0, 3), ea, ed,
         pa ? ea : ea ^ 32'h10, pd ? ed : ed + 1, pa ? ea : ea + 4);
  endtask

  // Start a run, drive the core buses cycle by cycle and check both instances.
  task automatic do_run(input string nm, input int len_in, input bit poke, input bit wr0);
    logic [31:0] pcs [MAXC], da [MAXC], dd [MAXC];
    int n, first, errs, cyc0, cyc1, cyc, ee, ef, cc;
    bit mm;
    if (wr0) begin
      m_instr[0] = $urandom; m_chk[0] = 0;
    end
    n = (len_in > DEPTH) ? DEPTH : len_in;
    for (int c = 0; c < MAXC; c++) begin
      pcs[c] = $urandom; da[c] = $urandom; dd[c] = $urandom;
    end
    for (int k = 0; k < n; k++) begin
      cc = k * H1 + H;
      da[cc] = c_a[k]; dd[cc] = c_d[k]; pcs[cc] = pcs[k * H1] + c_po[k];
    end
    first = -1; errs = 0;
    for (int k = 0; k < n; k++) begin
      cc = k * H1 + H;
      if (m_chk[k] == 1)      mm = (da[cc] != m_ea[k]) || (dd[cc] != m_ed[k]);
      else if (m_chk[k] == 2) mm = (pcs[cc] != pcs[k * H1] + m_ea[k]);
      else                    mm = 1'b0;
      if (mm) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    cyc0 = n * H1;
    cyc1 = (first >= 0) ? (first + 1) * H1 : cyc0;
    start_i = 1'b1; len_i = LW'(len_in);
    if (wr0) begin
      prog_we_i = 1'b1; prog_idx_i = '0; prog_instr_i = m_instr[0]; prog_chk_i = 2'd0;
    end
    for (int c = 0; c <= cyc0 + 1; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0; prog_we_i = 1'b0;
      for (int u = 0; u < 2; u++) begin
        cyc = (u == 0) ? cyc0 : cyc1;
        ee  = (u == 0) ? errs : ((first >= 0) ? 1 : 0);
        ef  = (first >= 0) ? first : 0;
        checks++;
        if (c < cyc) begin
          if (busy_w[u] !== 1'b1 || done_w[u] !== 1'b0 || instr_w[u] !== m_instr[c / H1]) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: busy=%b done=%b instr=%h, want busy=1 done=0 instr=%h",
                     nm, u, c, busy_w[u], done_w[u], instr_w[u], m_instr[c / H1]);
          end
        end else if (busy_w[u] !== 1'b0 || done_w[u] !== 1'b1 || pass_w[u] !== (ee == 0) ||
                     err_w[u] !== LW'(ee) || fidx_w[u] !== IW'(ef) || instr_w[u] !== NOP) begin
          errors++;
          $display("FAIL %s dut%0d cycle %0d: busy=%b done=%b pass=%b err=%0d fidx=%0d instr=%h, want 0 1 %b %0d %0d %h",
                   nm, u, c, busy_w[u], done_w[u], pass_w[u], err_w[u], fidx_w[u], instr_w[u],
                   (ee == 0), ee, ef, NOP);
        end
      end
      l1i_addr = pcs[c]; l1d_addr = da[c]; l1d_data = dd[c];
      if (poke && c == 2) begin
        start_i = 1'b1; len_i = LW'($urandom_range(1, DEPTH));
        prog_we_i = 1'b1; prog_idx_i = '0; prog_instr_i = ~m_instr[0]; prog_chk_i = 2'd1;
      end
    end
  endtask

  task automatic check_reset_vals(input string nm);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (instr_w[u] !== NOP || busy_w[u] !== 1'b0 || done_w[u] !== 1'b0 || pass_w[u] !== 1'b0 ||
          err_w[u] !== '0 || fidx_w[u] !== '0) begin
        errors++;
        $display("FAIL %s dut%0d: instr=%h busy=%b done=%b pass=%b err=%0d fidx=%0d, want %h 0 0 0 0 0",
                 nm, u, instr_w[u], busy_w[u], done_w[u], pass_w[u], err_w[u], fidx_w[u], NOP);
      end
    end
  endtask

  task automatic check_result(input string nm, input int u, input bit p, input int e, input int f);
    checks++;
    if (pass_w[u] !== p || err_w[u] !== LW'(e) || fidx_w[u] !== IW'(f)) begin
      errors++;
      $display("FAIL %s dut%0d: pass=%b err=%0d fidx=%0d, want %b %0d %0d",
               nm, u, pass_w[u], err_w[u], fidx_w[u], p, e, f);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; prog_we_i = 0; start_i = 0; prog_idx_i = 0; prog_instr_i = 0; prog_chk_i = 0;
    prog_exp_addr_i = 0; prog_exp_data_i = 0; len_i = 0; l1i_addr = 0; l1d_addr = 0; l1d_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_i = 1'b0;
  endtask

  task automatic test_addi_none;
    load(0, 32'h0010_0093, 0, 0, 0, 0, 0, 0);
    load(1, 32'h0020_0113, 0, 0, 0, 0, 0, 0);
    load(2, 32'h0030_0193, 0, 0, 0, 0, 0, 0);
    do_run("addi_none", 3, 0, 0);
    check_result("addi_none_res", 0, 1'b1, 0, 0);
  endtask

  task automatic test_dmem;
    load(2, 32'h0021_2023, 1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0);
    do_run("dmem_pass", 3, 0, 0);
    check_result("dmem_pass_res", 0, 1'b1, 0, 0);
    load(2, 32'h0021_2023, 1, 32'd2, 32'd3, 32'd2, 32'd2, 32'd0);
    do_run("dmem_fail", 3, 0, 0);
    check_result("dmem_fail_res", 0, 1'b0, 1, 2);
  endtask

  task automatic test_pc_rel;
    load(1, 32'h0000_0F63, 2, 32'd30, 32'd0, 32'd0, 32'd0, 32'd30);
    do_run("pcrel_pass", 2, 0, 0);
    check_result("pcrel_pass_res", 0, 1'b1, 0, 0);
    load(1, 32'h0000_0F63, 2, 32'd32, 32'd0, 32'd0, 32'd0, 32'd30);
    do_run("pcrel_fail", 2, 0, 0);
    check_result("pcrel_fail_res", 0, 1'b0, 1, 1);
  endtask

  task automatic test_stop_on_fail;
    load(0, 32'h0010_0093, 0, 0, 0, 0, 0, 0);
    load(1, 32'h0021_2023, 1, 32'd100, 32'd200, 32'd100, 32'd201, 0);
    load(2, 32'h0030_0193, 0, 0, 0, 0, 0, 0);
    load(3, 32'h0040_0213, 0, 0, 0, 0, 0, 0);
    do_run("stop", 4, 0, 0);
    check_result("stop_res_stop", 1, 1'b0, 1, 1);
    check_result("stop_res_run", 0, 1'b0, 1, 1);
  endtask

  task automatic test_len_zero;
    do_run("len_zero", 0, 0, 0);
  endtask

  task automatic test_len_clamp;
    for (int k = 0; k < DEPTH; k++) rand_entry(k);
    do_run("len_clamp", DEPTH + 3, 0, 0);
  endtask

  task automatic test_busy_ignore;
    do_run("busy_poke", 4, 1, 0);
    do_run("busy_after", 4, 0, 0);
  endtask

  task automatic test_write_and_start;
    do_run("wr_start", 3, 0, 1);
  endtask

  task automatic test_reset_mid;
    start_i = 1'b1; len_i = LW'(8);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0; l1i_addr = $urandom; l1d_addr = $urandom; l1d_data = $urandom;
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("reset_mid");
    rst_i = 1'b0;
    do_run("after_reset", 8, 0, 0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < DEPTH; k++) if ($urandom_range(0, 1) != 0) rand_entry(k);
      do_run("random", $urandom_range(1, DEPTH), 0, 0);
    end
  endtask

  initial begin
    test_reset;
    test_addi_none;
    test_dmem;
    test_pc_rel;
    test_stop_on_fail;
    test_len_zero;
    test_len_clamp;
    test_busy_ignore;
    test_write_and_start;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
